// File: rtl/bullet_controller_if.sv
// Bullet slot interface: fire request, spawn data and collision input from
// the game logic, plus the renderer-facing bullet outputs.
interface bullet_controller_if;
   logic        fire;
   logic [1:0]  dir;
   logic [10:0] SpawnX;
   logic [10:0] SpawnY;
   logic        hit;
   logic [10:0] BulletX;
   logic [10:0] BulletY;
   logic [10:0] BulletRadius;
   logic [15:0] BulletColor;
   logic        BulletActive;
   logic        ready;

   // Game logic side: issues fire/spawn/hit, observes the bullet.
   modport master (
      output fire, dir, SpawnX, SpawnY, hit,
      input  BulletX, BulletY, BulletRadius, BulletColor, BulletActive, ready
   );

   // Bullet controller side.
   modport slave (
      input  fire, dir, SpawnX, SpawnY, hit,
      output BulletX, BulletY, BulletRadius, BulletColor, BulletActive, ready
   );
endinterface

// File: rtl/bullet_controller.sv
// One bullet slot: spawns on an accepted fire request, moves SPEED pixels per
// frame tick along the latched direction, retires on a hit or when the next
// step would leave the screen, then holds off new fires for COOLDOWN ticks.
module bullet_controller #(
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned SPEED    = 4,
   parameter int unsigned RADIUS   = 3,
   parameter logic [15:0] COLOR    = 16'hFFE0,
   parameter int unsigned COOLDOWN = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 frame_clk,
   bullet_controller_if.slave   bus
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [10:0] W_LIMIT   = 11'(SCREEN_W);
   localparam logic [10:0] H_LIMIT   = 11'(SCREEN_H);
   localparam logic [11:0] X_MAX     = 12'(SCREEN_W - 1);
   localparam logic [11:0] Y_MAX     = 12'(SCREEN_H - 1);
   localparam logic [11:0] STEP      = 12'(SPEED);
   localparam logic [10:0] RADIUS_V  = 11'(RADIUS);
   localparam logic [7:0]  COOL_INIT = 8'(COOLDOWN);

   state_t      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [1:0]  dir_q, dir_d;
   logic [7:0]  cooldown_q, cooldown_d;
   logic        frame_q, frame_d;

   logic        tick;
   logic        ready_c;
   logic        step_neg;
   logic        step_on_x;
   logic [10:0] axis_pos;
   logic [11:0] next_pos;
   logic [11:0] axis_max;
   logic        off_screen;

   // Rising edge of the vertical sync level gives one move opportunity per frame.
   assign frame_d = frame_clk;
   assign tick    = frame_clk & ~frame_q;

   // Fire is accepted only when idle, cooled down, and spawning on screen.
   assign ready_c = (state_q == IDLE) && (cooldown_q == 8'd0) &&
                    (bus.SpawnX < W_LIMIT) && (bus.SpawnY < H_LIMIT);

   // Candidate next position on the travel axis, in 12-bit signed arithmetic
   // so that stepping past zero shows up as a set sign bit.
   always_comb begin
      step_on_x  = dir_q[1];
      step_neg   = ~dir_q[0];
      axis_pos   = step_on_x ? x_q : y_q;
      axis_max   = step_on_x ? X_MAX : Y_MAX;
      next_pos   = step_neg ? ({1'b0, axis_pos} - STEP) : ({1'b0, axis_pos} + STEP);
      off_screen = next_pos[11] || (next_pos > axis_max);
   end

   // Next-state and register update logic for the bullet lifetime FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_d      = dir_q;
      cooldown_d = cooldown_q;
      case (state_q)
         IDLE: begin
            if (bus.fire && ready_c) begin
               // A tick in the accept cycle is swallowed; the bullet appears at spawn.
               state_d = ACTIVE;
               x_d     = bus.SpawnX;
               y_d     = bus.SpawnY;
               dir_d   = bus.dir;
            end else if (tick && (cooldown_q != 8'd0)) begin
               cooldown_d = cooldown_q - 8'd1;
            end
         end
         ACTIVE: begin
            if (bus.hit) begin
               state_d    = IDLE;
               cooldown_d = COOL_INIT;
            end else if (tick) begin
               if (off_screen) begin
                  // Retire without moving; the last on-screen position is kept.
                  state_d    = IDLE;
                  cooldown_d = COOL_INIT;
               end else if (step_on_x) begin
                  x_d = next_pos[10:0];
               end else begin
                  y_d = next_pos[10:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         x_q        <= 11'd0;
         y_q        <= 11'd0;
         dir_q      <= 2'd0;
         cooldown_q <= 8'd0;
         frame_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops update from pre-edge values.
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dir_q      <= dir_d;
         cooldown_q <= cooldown_d;
         frame_q    <= frame_d;
      end
   end

   assign bus.BulletX      = x_q;
   assign bus.BulletY      = y_q;
   assign bus.BulletActive = (state_q == ACTIVE);
   assign bus.BulletRadius = (state_q == ACTIVE) ? RADIUS_V : 11'd0;
   assign bus.BulletColor  = COLOR;
   assign bus.ready        = ready_c;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller with hand-computed expectations.
module tb_bullet_controller;

   logic Clk;
   logic Reset;
   logic frame_clk;
   int   checks;
   int   failures;

   bullet_controller_if bus_if ();

   bullet_controller dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .bus       (bus_if)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One frame_clk rise, held high for two cycles to prove a single move per rise.
   task automatic frame_tick();
      frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
   endtask

   task automatic fire_once(input logic [10:0] sx, input logic [10:0] sy, input logic [1:0] d);
      bus_if.SpawnX = sx;
      bus_if.SpawnY = sy;
      bus_if.dir    = d;
      bus_if.fire   = 1'b1;
      @(negedge Clk);
      bus_if.fire   = 1'b0;
   endtask

   // Expects cooldown 8: ready low before each of 8 ticks, high after the 8th.
   task automatic run_cooldown(input string tag);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_busy"}, 32'(bus_if.ready), 32'd0);
         frame_tick();
      end
      check({tag, "_done"}, 32'(bus_if.ready), 32'd1);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      Reset         = 1'b1;
      frame_clk     = 1'b0;
      bus_if.fire   = 1'b0;
      bus_if.hit    = 1'b0;
      bus_if.dir    = 2'd0;
      bus_if.SpawnX = 11'd320;
      bus_if.SpawnY = 11'd240;
      repeat (2) @(negedge Clk);

      check("rst_active", 32'(bus_if.BulletActive), 32'd0);
      check("rst_radius", 32'(bus_if.BulletRadius), 32'd0);
      check("rst_ready",  32'(bus_if.ready),        32'd1);
      check("rst_x",      32'(bus_if.BulletX),      32'd0);
      check("rst_y",      32'(bus_if.BulletY),      32'd0);
      check("color",      32'(bus_if.BulletColor),  32'hFFE0);
      Reset = 1'b0;
      @(negedge Clk);

      // Spawn at centre, heading up.
      fire_once(11'd320, 11'd240, 2'd0);
      check("t1_active", 32'(bus_if.BulletActive), 32'd1);
      check("t1_x",      32'(bus_if.BulletX),      32'd320);
      check("t1_y",      32'(bus_if.BulletY),      32'd240);
      check("t1_radius", 32'(bus_if.BulletRadius), 32'd3);
      check("t1_ready",  32'(bus_if.ready),        32'd0);

      // Ten frame ticks, 4 px up each.
      for (int i = 1; i <= 10; i++) begin
         frame_tick();
         check("t2_y", 32'(bus_if.BulletY), 32'(240 - 4 * i));
      end
      check("t2_x", 32'(bus_if.BulletX), 32'd320);

      // Hit and tick together: hit wins, no advance.
      bus_if.hit = 1'b1;
      frame_clk  = 1'b1;
      @(negedge Clk);
      bus_if.hit = 1'b0;
      frame_clk  = 1'b0;
      check("t4_active", 32'(bus_if.BulletActive), 32'd0);
      check("t4_y",      32'(bus_if.BulletY),      32'd200);
      check("t4_radius", 32'(bus_if.BulletRadius), 32'd0);
      @(negedge Clk);
      run_cooldown("t4_cd");

      // Right edge: 636 + 4 = 640 leaves the screen.
      fire_once(11'd636, 11'd100, 2'd3);
      check("t3_active", 32'(bus_if.BulletActive), 32'd1);
      frame_tick();
      check("t3_retire", 32'(bus_if.BulletActive), 32'd0);
      check("t3_x",      32'(bus_if.BulletX),      32'd636);
      fire_once(11'd320, 11'd240, 2'd0);
      check("t3_cd_fire", 32'(bus_if.BulletActive), 32'd0);
      run_cooldown("t3_cd");

      // Fire with a simultaneous tick: tick consumed, no move.
      bus_if.SpawnX = 11'd50;
      bus_if.SpawnY = 11'd2;
      bus_if.dir    = 2'd0;
      bus_if.fire   = 1'b1;
      frame_clk     = 1'b1;
      @(negedge Clk);
      bus_if.fire   = 1'b0;
      frame_clk     = 1'b0;
      check("t5_active", 32'(bus_if.BulletActive), 32'd1);
      check("t5_y",      32'(bus_if.BulletY),      32'd2);
      @(negedge Clk);
      check("t5_y_hold", 32'(bus_if.BulletY),      32'd2);
      frame_tick();
      check("t5_retire", 32'(bus_if.BulletActive), 32'd0);
      check("t5_y_keep", 32'(bus_if.BulletY),      32'd2);
      run_cooldown("t5_cd");

      // Left travel moves X only; down travel retires at the bottom edge.
      fire_once(11'd100, 11'd50, 2'd2);
      frame_tick();
      check("left_x", 32'(bus_if.BulletX), 32'd96);
      check("left_y", 32'(bus_if.BulletY), 32'd50);

      // Asynchronous reset between edges while in flight.
      #2 Reset = 1'b1;
      #1;
      check("t6_active", 32'(bus_if.BulletActive), 32'd0);
      check("t6_radius", 32'(bus_if.BulletRadius), 32'd0);
      check("t6_ready",  32'(bus_if.ready),        32'd1);
      bus_if.SpawnX = 11'd700;
      #1;
      check("t6_ready_oob", 32'(bus_if.ready), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      bus_if.fire = 1'b1;
      @(negedge Clk);
      bus_if.fire = 1'b0;
      check("t6_fire_oob", 32'(bus_if.BulletActive), 32'd0);

      // Bottom edge: 476 + 4 = 480 leaves the screen.
      fire_once(11'd10, 11'd476, 2'd1);
      check("down_active", 32'(bus_if.BulletActive), 32'd1);
      frame_tick();
      check("down_retire", 32'(bus_if.BulletActive), 32'd0);
      check("down_y",      32'(bus_if.BulletY),      32'd476);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
